// File: rtl/rand_hold_scheduler_pkg.sv
// Shared types and constants for the random hold scheduler.
package rand_hold_scheduler_pkg;

   typedef enum logic [1:0] {
      IDLE,
      GAP,
      RELEASE
   } state_e;

   localparam int unsigned            LfsrWidth   = 16;
   localparam logic [LfsrWidth-1:0]   LfsrTaps    = 16'hB400;
   localparam logic [LfsrWidth-1:0]   DefaultSeed = 16'hACE1;

endpackage

// File: rtl/rhs_lfsr.sv
// Free-running Galois LFSR (right-shifting form) used for gap/release timing draws.
module rhs_lfsr
   import rand_hold_scheduler_pkg::*;
#(
   parameter int unsigned      Width = LfsrWidth,
   parameter logic [Width-1:0] Taps  = LfsrTaps,
   parameter logic [Width-1:0] Seed  = DefaultSeed
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   output logic [Width-1:0] state
);

   // An all-zero state would lock up the LFSR, so it is remapped to 1.
   localparam logic [Width-1:0] SeedEff = (Seed == '0) ? Width'(1) : Seed;

   // Shift right and fold the taps in whenever a one falls out of bit 0.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= SeedEff;
      end else if (en) begin
         state <= {1'b0, state[Width-1:1]} ^ (state[0] ? Taps : '0);
      end
   end

endmodule

// File: rtl/rand_hold_scheduler.sv
// Shares one update slot between holdable drivers: all held by default, one requester
// released at a time in round-robin order for LFSR-drawn release lengths and gaps.
module rand_hold_scheduler
   import rand_hold_scheduler_pkg::*;
#(
   parameter int unsigned          NumDrivers = 4,
   parameter int unsigned          MinGap     = 0,
   parameter int unsigned          MaxGap     = 7,
   parameter int unsigned          MinRelease = 1,
   parameter int unsigned          MaxRelease = 4,
   parameter logic [LfsrWidth-1:0] LfsrSeed   = DefaultSeed
) (
   input  logic                          clk_i,
   input  logic                          rst_i,
   input  logic                          en_i,
   input  logic [NumDrivers-1:0]         req_i,
   output logic [NumDrivers-1:0]         hold_o,
   output logic                          grant_valid_o,
   output logic [$clog2(NumDrivers)-1:0] grant_idx_o
);

   localparam int unsigned IdxW    = $clog2(NumDrivers);
   localparam int unsigned GapSpan = MaxGap - MinGap + 1;
   localparam int unsigned RelSpan = MaxRelease - MinRelease + 1;
   localparam int unsigned CntMax  = (MaxGap > MaxRelease) ? MaxGap : MaxRelease;
   localparam int unsigned CntW    = $clog2(CntMax + 1);

   if (NumDrivers < 2) begin : g_chk_drivers
      $fatal(1, "rand_hold_scheduler: NumDrivers must be >= 2");
   end
   if (MaxGap < MinGap) begin : g_chk_gap
      $fatal(1, "rand_hold_scheduler: MaxGap must be >= MinGap");
   end
   if (MinRelease < 1) begin : g_chk_rel_min
      $fatal(1, "rand_hold_scheduler: MinRelease must be >= 1");
   end
   if (MaxRelease < MinRelease) begin : g_chk_rel_max
      $fatal(1, "rand_hold_scheduler: MaxRelease must be >= MinRelease");
   end

   state_e                  state_q, state_d;
   logic [CntW-1:0]         cnt_q, cnt_d;
   logic [IdxW-1:0]         rr_q, rr_d;
   logic [IdxW-1:0]         idx_q, idx_d;
   logic                    valid_q, valid_d;
   logic [NumDrivers-1:0]   hold_q, hold_d;
   logic [LfsrWidth-1:0]    lfsr;
   logic [CntW-1:0]         gap_draw;
   logic [CntW-1:0]         rel_draw_m1;
   logic [IdxW-1:0]         winner;
   logic [IdxW-1:0]         rr_next;

   rhs_lfsr #(
      .Width (LfsrWidth),
      .Taps  (LfsrTaps),
      .Seed  (LfsrSeed)
   ) u_lfsr (
      .clk   (clk_i),
      .rst   (rst_i),
      .en    (1'b1),
      .state (lfsr)
   );

   // Release count is loaded minus one so the RELEASE state lasts exactly rel cycles.
   assign gap_draw    = CntW'(MinGap + (32'(lfsr) % GapSpan));
   assign rel_draw_m1 = CntW'(MinRelease - 1 + (32'(lfsr) % RelSpan));

   // Round-robin pick: first requester at or after the pointer, wrapping.
   always_comb begin
      int pos;
      pos    = 0;
      winner = rr_q;
      for (int k = int'(NumDrivers) - 1; k >= 0; k--) begin
         pos = (int'(rr_q) + k) % int'(NumDrivers);
         if (req_i[pos]) begin
            winner = IdxW'(pos);
         end
      end
   end

   assign rr_next = (winner == IdxW'(NumDrivers - 1)) ? '0 : winner + IdxW'(1);

   // Next-state, counter and registered-output logic.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rr_d    = rr_q;
      idx_d   = idx_q;
      valid_d = valid_q;
      if (!en_i) begin
         state_d = IDLE;
         cnt_d   = '0;
         valid_d = 1'b0;
         idx_d   = '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (|req_i) begin
                  state_d = GAP;
                  cnt_d   = gap_draw;
               end
            end
            GAP: begin
               if (cnt_q != '0) begin
                  cnt_d = cnt_q - CntW'(1);
               end else if (|req_i) begin
                  state_d = RELEASE;
                  cnt_d   = rel_draw_m1;
                  idx_d   = winner;
                  valid_d = 1'b1;
                  rr_d    = rr_next;
               end else begin
                  state_d = IDLE;
               end
            end
            RELEASE: begin
               // A dropped request ends the release early; the driver is re-held next cycle.
               if (!req_i[idx_q] || cnt_q == '0) begin
                  state_d = GAP;
                  cnt_d   = gap_draw;
                  valid_d = 1'b0;
                  idx_d   = '0;
               end else begin
                  cnt_d = cnt_q - CntW'(1);
               end
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end
      hold_d = ~(NumDrivers'(valid_d) << idx_d);
   end

   // State and output registers; reset holds every driver immediately.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         rr_q    <= '0;
         idx_q   <= '0;
         valid_q <= 1'b0;
         hold_q  <= '1;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rr_q    <= rr_d;
         idx_q   <= idx_d;
         valid_q <= valid_d;
         hold_q  <= hold_d;
      end
   end

   assign hold_o        = hold_q;
   assign grant_valid_o = valid_q;
   assign grant_idx_o   = idx_q;

endmodule

// File: tb/tb_rand_hold_scheduler.sv
// Bench: dut_a (default timing) runs random stimulus against a reference model the whole
// time; dut_b (gap 0, release 2) and dut_c (gap 0, release 4) get directed scenarios.
module tb_rand_hold_scheduler;

   localparam int N      = 4;
   localparam int GapLo  = 0;
   localparam int GapHi  = 7;
   localparam int RelLo  = 1;
   localparam int RelHi  = 4;
   localparam int PhIdle = 0;
   localparam int PhGap  = 1;
   localparam int PhRel  = 2;

   logic         clk = 1'b0;
   logic         rst;
   logic         en_a, en_b, en_c;
   logic [N-1:0] req_a, req_b, req_c;
   logic [N-1:0] hold_a, hold_b, hold_c;
   logic         valid_a, valid_b, valid_c;
   logic [1:0]   idx_a, idx_b, idx_c;

   int total = 0;
   int bad   = 0;

   // Reference model state for dut_a.
   int          m_phase = PhIdle;
   int          m_gap_left = 0;
   int          m_rel_len = 0;
   int          m_rel_served = 0;
   int          m_rr = 0;
   int          m_idx = 0;
   bit          m_valid = 1'b0;
   int unsigned m_lfsr = 32'hACE1;

   // Phase-2 run-length tracking on dut_a.
   bit a_all = 1'b0;
   int a_warm = 0;
   bit armed_rel = 1'b0;
   bit armed_gap = 1'b0;
   int rel_run = 0;
   int gap_run = 0;
   bit prev_valid = 1'b0;
   int prev_idx = 0;

   always #5 clk = ~clk;

   rand_hold_scheduler #(
      .NumDrivers (N), .MinGap (GapLo), .MaxGap (GapHi),
      .MinRelease (RelLo), .MaxRelease (RelHi), .LfsrSeed (16'hACE1)
   ) dut_a (
      .clk_i (clk), .rst_i (rst), .en_i (en_a), .req_i (req_a),
      .hold_o (hold_a), .grant_valid_o (valid_a), .grant_idx_o (idx_a)
   );

   rand_hold_scheduler #(
      .NumDrivers (N), .MinGap (0), .MaxGap (0),
      .MinRelease (2), .MaxRelease (2), .LfsrSeed (16'h1234)
   ) dut_b (
      .clk_i (clk), .rst_i (rst), .en_i (en_b), .req_i (req_b),
      .hold_o (hold_b), .grant_valid_o (valid_b), .grant_idx_o (idx_b)
   );

   rand_hold_scheduler #(
      .NumDrivers (N), .MinGap (0), .MaxGap (0),
      .MinRelease (4), .MaxRelease (4), .LfsrSeed (16'h0000)
   ) dut_c (
      .clk_i (clk), .rst_i (rst), .en_i (en_c), .req_i (req_c),
      .hold_o (hold_c), .grant_valid_o (valid_c), .grant_idx_o (idx_c)
   );

   task automatic check(input string tag, input int obs, input int exp);
      total++;
      if (obs != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // who < 0 means every driver held.
   task automatic expect_grant(input string tag, input logic [N-1:0] hold, input logic valid,
                               input logic [1:0] idx, input int who);
      logic [N-1:0] want;
      want = '1;
      if (who >= 0) want[who] = 1'b0;
      check({tag, "/hold"}, int'(hold), int'(want));
      check({tag, "/valid"}, int'(valid), (who >= 0) ? 1 : 0);
      check({tag, "/idx"}, int'(idx), (who >= 0) ? who : 0);
   endtask

   // Behavioural scheduler: one update per rising edge with the inputs seen at that edge.
   task automatic model_step(input bit r, input bit en, input logic [N-1:0] req);
      int gap_len;
      int rel_len;
      int pick;
      if (r) begin
         m_phase = PhIdle; m_rr = 0; m_idx = 0; m_valid = 1'b0; m_lfsr = 32'hACE1;
         return;
      end
      gap_len = GapLo + int'(m_lfsr % (GapHi - GapLo + 1));
      rel_len = RelLo + int'(m_lfsr % (RelHi - RelLo + 1));
      if (!en) begin
         m_phase = PhIdle; m_valid = 1'b0; m_idx = 0;
      end else if (m_phase == PhIdle) begin
         if (req != 0) begin
            m_phase = PhGap; m_gap_left = gap_len;
         end
      end else if (m_phase == PhGap) begin
         if (m_gap_left > 0) begin
            m_gap_left--;
         end else if (req != 0) begin
            pick = -1;
            for (int k = 0; k < N; k++) begin
               if (pick < 0 && req[(m_rr + k) % N]) pick = (m_rr + k) % N;
            end
            m_phase = PhRel; m_idx = pick; m_valid = 1'b1;
            m_rel_len = rel_len; m_rel_served = 1; m_rr = (pick + 1) % N;
         end else begin
            m_phase = PhIdle;
         end
      end else begin
         if (!req[m_idx] || m_rel_served == m_rel_len) begin
            m_phase = PhGap; m_gap_left = gap_len; m_valid = 1'b0; m_idx = 0;
         end else begin
            m_rel_served++;
         end
      end
      m_lfsr = ((m_lfsr >> 1) ^ (((m_lfsr & 1) != 0) ? 32'hB400 : 32'h0)) & 32'hFFFF;
   endtask

   task automatic tick();
      int zeros;
      logic [N-1:0] mh;
      @(posedge clk);
      model_step(rst, en_a, req_a);
      #1;
      mh = '1;
      if (m_valid) mh[m_idx] = 1'b0;
      check("a_hold", int'(hold_a), int'(mh));
      check("a_valid", int'(valid_a), int'(m_valid));
      check("a_idx", int'(idx_a), m_valid ? m_idx : 0);
      zeros = 0;
      for (int i = 0; i < N; i++) if (!hold_a[i]) zeros++;
      check("a_one_zero", int'(zeros <= 1), 1);
      if (a_all && a_warm > 0) begin
         a_warm--;
      end else if (a_all) begin
         if (valid_a) begin
            if (!prev_valid) begin
               if (armed_gap)
                  check("a_gap_len", int'(gap_run >= GapLo + 1 && gap_run <= GapHi + 1), 1);
               armed_rel = 1'b1;
               rel_run = 1;
            end else begin
               rel_run++;
               check("a_stable_idx", int'(idx_a), prev_idx);
            end
         end else begin
            if (prev_valid) begin
               if (armed_rel)
                  check("a_rel_len", int'(rel_run >= RelLo && rel_run <= RelHi), 1);
               armed_gap = 1'b1;
               gap_run = 1;
            end else begin
               gap_run++;
            end
         end
      end
      prev_valid = valid_a;
      prev_idx = int'(idx_a);
      if (a_all) begin
         en_a = 1'b1;
         req_a = '1;
      end else begin
         if ($urandom % 8 == 0) req_a = N'($urandom);
         en_a = ($urandom % 32) != 0;
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      #1;
      tick();
      rst = 1'b0;
   endtask

   initial begin
      int seq_rr[15];
      int seq_sp[9];
      seq_rr = '{-1, 0, 0, -1, 1, 1, -1, 2, 2, -1, 3, 3, -1, 0, 0};
      seq_sp = '{-1, 1, 1, -1, 3, 3, -1, 1, 1};
      rst = 1'b0; en_a = 1'b0; req_a = '0; en_b = 1'b1; req_b = '0; en_c = 1'b1; req_c = '0;
      #2 rst = 1'b1;
      #1;
      expect_grant("reset_b", hold_b, valid_b, idx_b, -1);
      expect_grant("reset_c", hold_c, valid_c, idx_c, -1);
      tick();
      tick();
      rst = 1'b0;

      // No requests after reset: stays idle with everyone held.
      repeat (3) begin
         tick();
         expect_grant("idle_b", hold_b, valid_b, idx_b, -1);
      end

      // Round robin over all four drivers.
      req_b = 4'b1111;
      foreach (seq_rr[i]) begin
         tick();
         expect_grant("rr_b", hold_b, valid_b, idx_b, seq_rr[i]);
      end

      // Sparse requesters from rr pointer 0.
      req_b = 4'b1010;
      do_reset();
      foreach (seq_sp[i]) begin
         tick();
         expect_grant("sparse_b", hold_b, valid_b, idx_b, seq_sp[i]);
      end
      req_b = '0;

      // Early drop by driver 2 in its first released cycle.
      req_c = 4'b0100;
      do_reset();
      tick();
      expect_grant("drop_gap", hold_c, valid_c, idx_c, -1);
      tick();
      expect_grant("drop_grant2", hold_c, valid_c, idx_c, 2);
      req_c = 4'b0001;
      tick();
      expect_grant("drop_reheld", hold_c, valid_c, idx_c, -1);
      repeat (4) begin
         tick();
         expect_grant("drop_grant0", hold_c, valid_c, idx_c, 0);
      end
      tick();
      expect_grant("drop_after", hold_c, valid_c, idx_c, -1);

      // Enable dropped mid-release, then resumed at the rr pointer.
      req_c = 4'b1111;
      do_reset();
      tick();
      expect_grant("en_gap", hold_c, valid_c, idx_c, -1);
      tick();
      expect_grant("en_grant0a", hold_c, valid_c, idx_c, 0);
      tick();
      expect_grant("en_grant0b", hold_c, valid_c, idx_c, 0);
      en_c = 1'b0;
      repeat (3) begin
         tick();
         expect_grant("en_off", hold_c, valid_c, idx_c, -1);
      end
      en_c = 1'b1;
      tick();
      expect_grant("en_regap", hold_c, valid_c, idx_c, -1);
      tick();
      expect_grant("en_resume1", hold_c, valid_c, idx_c, 1);

      // Asynchronous reset while driver 1 is released.
      rst = 1'b1;
      #1;
      expect_grant("async_rst", hold_c, valid_c, idx_c, -1);
      tick();
      rst = 1'b0;

      // Random phase on dut_a, then a long all-requesting run with length checks.
      repeat (2000) tick();
      a_all = 1'b1;
      a_warm = 2;
      armed_rel = 1'b0;
      armed_gap = 1'b0;
      repeat (10000) tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
